preg_free_list: RTL and testbench
=================================

// Module: preg_free_list
// PURPOSE
//  Allocator and free-pool manager for the physical register file used by rename.
//  Hands out one free physical register (preg) per cycle to rename, for a renamed rd.
//  Accepts one preg per cycle back from retire (the stale mapping of a committed rd).
//  Replaces ad-hoc linear search of the p_regs busy column; is the sole owner of preg busy state.
// PARAMETERS
//  NUM_PREGS  64  physical registers; power of two
//  NUM_AREGS  32  architectural registers; x_i maps to p_i at reset
//  PREG_W     6   $clog2(NUM_PREGS); preg index width
//  FL_DEPTH   32  NUM_PREGS-NUM_AREGS; free-list FIFO capacity (power of two)
// PORTS
//  clk             in   1           rising-edge clock
//  reset           in   1           synchronous, active-high
//  alloc_req       in   1           rename needs a preg this cycle
//  alloc_valid     out  1           grant: alloc_preg valid and popped at this edge
//  alloc_preg      out  PREG_W      granted preg index
//  free_valid      in   1           retire returns free_preg this cycle
//  free_preg       in   PREG_W      preg to return to the pool
//  free_count      out  PREG_W+1    number of free pregs (0..FL_DEPTH)
//  empty           out  1           free_count==0
//  full            out  1           free_count==FL_DEPTH
//  err_free        out  1           one-cycle pulse: illegal free dropped
// BEHAVIOUR
//  State: circular FIFO fifo[FL_DEPTH] of preg indices; head, tail ptrs (log2 FL_DEPTH bits,
//   wrap naturally); count reg; busy[NUM_PREGS] bit vector.
//  Reset (sync, 1 cycle): fifo[i]=NUM_AREGS+i; head=0; tail=0; count=FL_DEPTH;
//   busy[i]=1 for i<NUM_AREGS, else 0. Outputs while reset high: alloc_valid=0, err_free=0,
//   free_count=FL_DEPTH, full=1, empty=0. Reset mid-operation discards all state; in-flight
//   requests in that cycle ignored.
//  Alloc (combinational grant, 0-cycle latency): alloc_valid = alloc_req & ~empty & ~reset;
//   alloc_preg = fifo[head] (driven even if not valid). On grant at edge: head++,
//   busy[alloc_preg]<=1.
//  Free (takes effect at edge): legal iff free_valid & busy[free_preg] & free_preg!=0 & ~full.
//   Legal: fifo[tail]<=free_preg, tail++, busy[free_preg]<=0.
//   Illegal (not busy = double free, p0, or full): dropped, err_free=1 next cycle, no state change.
//  count update: count + legal_free - alloc_grant; both same cycle -> count unchanged.
//  Empty + free same cycle: alloc denied (no bypass); freed preg available next cycle.
//  Full + alloc + free same cycle: free counted against post-pop occupancy only if
//   alloc granted -> legal; without alloc -> illegal (err_free).
//  free_count/empty/full derive from the count register (registered, reflect prior edges).
//  Invariant: count + popcount(busy) == NUM_PREGS at every edge; checked in sim.
// STRUCTURE
//  Add to package p: NUM_PREGS, NUM_AREGS, PREG_W, FL_DEPTH localparams; typedef logic
//   [PREG_W-1:0] preg_t. Rename and retire import preg_t from p.
//  One sub-module: preg_fifo (circular buffer, push/pop, head/tail/count, reset-init contents);
//   preg_free_list wraps it with busy vector, legality checks and error pulse.
// TESTING
//  Reset: after reset, free_count=32, full=1, alloc_preg=32, busy[31:0] set, err_free=0.
//  Drain: alloc_req=1 for 33 cycles -> grants p32..p63 in order, cycle 33 alloc_valid=0, empty=1.
//  Recycle: after drain, free p5 -> next cycle alloc_preg=5, alloc_valid=1; empty again after.
//  Simultaneous: full, alloc_req=1 + free p3 (busy) -> grant p32, p3 enqueued, count stays 32.
//  Illegal frees: free p40 while free -> err_free=1, count unchanged; free p0 -> err_free=1.
//  Reset mid-run: after 10 allocs+4 frees assert reset 1 cycle -> state equals Reset case.

Source files
------------

// File: rtl/preg_free_list_pkg.sv
// Shared types and sizing for the physical-register free list.
// Rename and retire import preg_t from here.
package preg_free_list_pkg;
  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int PREG_W    = $clog2(NUM_PREGS);
  localparam int FL_DEPTH  = NUM_PREGS - NUM_AREGS;
  localparam int PTR_W     = $clog2(FL_DEPTH);
  localparam int CNT_W     = PREG_W + 1;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [CNT_W-1:0]  cnt_t;
endpackage

// File: rtl/preg_free_list_fifo.sv
// Circular buffer of free preg indices; reset preloads the pregs above the
// architectural set so the pool starts full.
module preg_fifo
  import preg_free_list_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  preg_t push_data,
  input  logic  pop,
  output preg_t head_data,
  output cnt_t  count
);

  preg_t             mem [FL_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) mem[i] <= preg_t'(NUM_AREGS + i);
      head  <= '0;
      tail  <= '0;
      count <= cnt_t'(FL_DEPTH);
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count <= count + cnt_t'(push) - cnt_t'(pop);
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/preg_free_list.sv
// Physical register allocator: one grant per cycle to rename, one return per
// cycle from retire. Owns the preg busy vector and rejects illegal frees.
module preg_free_list
  import preg_free_list_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  alloc_req,
  output logic  alloc_valid,
  output preg_t alloc_preg,
  input  logic  free_valid,
  input  preg_t free_preg,
  output cnt_t  free_count,
  output logic  empty,
  output logic  full,
  output logic  err_free
);

  logic [NUM_PREGS-1:0] busy;
  cnt_t                 count;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 legal_free;
  logic                 err_q;

  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == cnt_t'(FL_DEPTH));
  assign alloc_valid = alloc_req & ~fifo_empty & ~reset;

  // A free into a full pool is only room-safe when the same edge pops one.
  assign legal_free = free_valid & ~reset & busy[free_preg] &
                      (free_preg != '0) & (~fifo_full | alloc_valid);

  preg_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (legal_free),
    .push_data (free_preg),
    .pop       (alloc_valid),
    .head_data (alloc_preg),
    .count     (count)
  );

  // Granted and freed pregs can never collide: one is free, the other busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= {{FL_DEPTH{1'b0}}, {NUM_AREGS{1'b1}}};
      err_q <= 1'b0;
    end else begin
      if (alloc_valid) busy[alloc_preg] <= 1'b1;
      if (legal_free)  busy[free_preg]  <= 1'b0;
      err_q <= free_valid & ~legal_free;
    end
  end

  assign free_count = reset ? cnt_t'(FL_DEPTH) : count;
  assign empty      = ~reset & fifo_empty;
  assign full       = reset | fifo_full;
  assign err_free   = ~reset & err_q;

endmodule

// File: tb/tb_preg_free_list.sv
// Directed and random checks of the preg free list against a queue model;
// expected grants flow through a scoreboard queue.
module tb_preg_free_list;
  import preg_free_list_pkg::*;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  logic  alloc_req = 1'b0;
  logic  alloc_valid;
  preg_t alloc_preg;
  logic  free_valid = 1'b0;
  preg_t free_preg = '0;
  cnt_t  free_count;
  logic  empty, full, err_free;

  int checks = 0;
  int errors = 0;

  int mq[$];
  int exp_q[$];
  bit mbusy [NUM_PREGS];

  preg_free_list dut (
    .clk        (clk),
    .reset      (reset),
    .alloc_req  (alloc_req),
    .alloc_valid(alloc_valid),
    .alloc_preg (alloc_preg),
    .free_valid (free_valid),
    .free_preg  (free_preg),
    .free_count (free_count),
    .empty      (empty),
    .full       (full),
    .err_free   (err_free)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    mq.delete();
    exp_q.delete();
    for (int i = 0; i < FL_DEPTH; i++) mq.push_back(NUM_AREGS + i);
    for (int i = 0; i < NUM_PREGS; i++) mbusy[i] = (i < NUM_AREGS);
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input bit req, input bit fv, input int fp);
    bit exp_valid, legal;
    int got;
    alloc_req  = req;
    free_valid = fv;
    free_preg  = preg_t'(fp);
    exp_valid  = req && (mq.size() > 0);
    legal      = fv && mbusy[fp] && (fp != 0) && ((mq.size() != FL_DEPTH) || exp_valid);
    if (exp_valid) exp_q.push_back(mq[0]);
    @(negedge clk);
    chk("alloc_valid", 32'(alloc_valid), 32'(exp_valid));
    if (alloc_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_grant", 32'd1, 32'd0);
      else begin
        got = exp_q.pop_front();
        chk("alloc_preg", 32'(alloc_preg), 32'(got));
      end
    end
    chk("free_count", 32'(free_count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == FL_DEPTH));
    chk("invariant", 32'(free_count) + 32'($countones(dut.busy)), 32'(NUM_PREGS));
    @(posedge clk);
    if (exp_valid) begin
      mbusy[mq[0]] = 1'b1;
      void'(mq.pop_front());
    end
    if (legal) begin
      mq.push_back(fp);
      mbusy[fp] = 1'b0;
    end
    #1;
    chk("err_free", 32'(err_free), 32'(fv && !legal));
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    alloc_req  = 1'b1;
    free_valid = 1'b1;
    free_preg  = preg_t'(3);
    @(negedge clk);
    chk("rst_alloc_valid", 32'(alloc_valid), 32'd0);
    chk("rst_err_free", 32'(err_free), 32'd0);
    chk("rst_free_count", 32'(free_count), 32'(FL_DEPTH));
    chk("rst_full", 32'(full), 32'd1);
    chk("rst_empty", 32'(empty), 32'd0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    model_init();
    @(negedge clk);
    chk("post_rst_alloc_preg", 32'(alloc_preg), 32'd32);
    chk("post_rst_busy_lo", dut.busy[31:0], 32'hffff_ffff);
    chk("post_rst_busy_hi", dut.busy[63:32], 32'h0);
    chk("post_rst_err_free", 32'(err_free), 32'd0);
    chk("post_rst_free_count", 32'(free_count), 32'(FL_DEPTH));
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();

    // Drain: 32 grants p32..p63, 33rd denied
    for (int i = 0; i < 33; i++) step(1'b1, 1'b0, 0);
    // Recycle p5 with alloc asserted the same cycle: denied, then granted next
    step(1'b1, 1'b1, 5);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);

    // Full: alloc + free of busy p3 -> legal, count stays 32
    do_reset();
    step(1'b1, 1'b1, 3);
    // Full without alloc: free of busy p4 is illegal
    step(1'b0, 1'b1, 4);
    // Free of an already-free preg and of p0
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 40);
    step(1'b0, 1'b1, 0);
    // Double free of p3 after it was re-pooled
    step(1'b0, 1'b1, 3);

    // Mid-run reset after 10 allocs and 4 frees
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32 + i);
    do_reset();

    for (int i = 0; i < 300; i++)
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), int'($urandom_range(0, NUM_PREGS - 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
